// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game body logic.
package snake_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_t;

    typedef logic [7:0] coord_t;

    localparam int     GRID_MAX  = 15;
    localparam coord_t INIT_HEAD = 8'h35;
    localparam coord_t INIT_BODY = 8'h25;

    function automatic dir_t reverse_dir(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

    // Returns {x[4:0], y[4:0]}; the extra bit makes a step off the grid visible.
    function automatic logic [9:0] step_head(input coord_t h, input dir_t d);
        logic [4:0] nx;
        logic [4:0] ny;
        nx = {1'b0, h[7:4]};
        ny = {1'b0, h[3:0]};
        case (d)
            UP:      ny = ny - 5'd1;
            DOWN:    ny = ny + 5'd1;
            LEFT:    nx = nx - 5'd1;
            default: nx = nx + 5'd1;
        endcase
        return {nx, ny};
    endfunction

endpackage

// File: rtl/snake_collide.sv
// Combinational wall and self-collision check for a proposed new head position.
module snake_collide
    import snake_pkg::*;
#(
    parameter int MAX_LENGTH = 50,
    parameter int LEN_W      = $clog2(MAX_LENGTH + 1)
) (
    input  logic [9:0]                  new_head,
    input  logic [MAX_LENGTH-1:0][7:0]  body,
    input  logic [LEN_W-1:0]            length,
    input  logic                        grow,
    output logic                        wall_hit,
    output logic                        self_hit
);
    logic [LEN_W-1:0]      limit;
    logic [MAX_LENGTH-1:0] match;
    coord_t                head_cell;

    assign wall_hit  = (new_head[9:5] > 5'(GRID_MAX)) || (new_head[4:0] > 5'(GRID_MAX));
    assign head_cell = {new_head[8:5], new_head[3:0]};

    // Without growth the tail cell is vacated during this move, so it is excluded.
    assign limit = grow ? length : length - LEN_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < MAX_LENGTH; gi++) begin : g_cmp
            assign match[gi] = (LEN_W'(gi) < limit) && (body[gi] == head_cell);
        end
    endgenerate

    assign self_hit = |match;

endmodule

// File: rtl/snake_body.sv
// Snake owner: body shift array, direction control, growth, collisions and a
// registered per-pixel occupancy query for the renderer.
module snake_body
    import snake_pkg::*;
#(
    parameter int MAX_LENGTH = 50,
    parameter int LEN_W      = $clog2(MAX_LENGTH + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        move_tick,
    input  logic                        dir_valid,
    input  logic [1:0]                  dir,
    input  logic [7:0]                  apple_cord,
    input  logic                        apple_valid,
    input  logic [3:0]                  x,
    input  logic [3:0]                  y,
    output logic [MAX_LENGTH-1:0][7:0]  body,
    output logic [LEN_W-1:0]            length,
    output logic                        good_coll,
    output logic                        bad_coll,
    output logic                        game_over,
    output logic                        snake_px,
    output logic                        head_px
);
    localparam logic [MAX_LENGTH-1:0][7:0] INIT_LAYOUT =
        {{(MAX_LENGTH-1){INIT_BODY}}, INIT_HEAD};

    state_t                     state_q, state_d;
    logic [MAX_LENGTH-1:0][7:0] body_q, body_d, moved_body;
    logic [LEN_W-1:0]           len_q, len_d, len_grown;
    dir_t                       cur_dir_q, cur_dir_d, next_dir_q, next_dir_d;
    dir_t                       dir_in, dir_chosen;
    logic                       good_q, good_d, bad_q, bad_d;
    logic                       snake_px_q, snake_px_d, head_px_q, head_px_d;
    logic                       dir_ok, grow, wall_hit, self_hit;
    logic [9:0]                 new_head_ext;
    coord_t                     new_head, new_tail;
    logic [MAX_LENGTH-1:0]      px_hit;

    assign dir_in       = dir_t'(dir);
    assign dir_ok       = dir_valid && (dir_in != reverse_dir(cur_dir_q));
    assign dir_chosen   = dir_ok ? dir_in : next_dir_q;
    assign new_head_ext = step_head(body_q[0], dir_chosen);
    assign new_head     = {new_head_ext[8:5], new_head_ext[3:0]};
    assign grow         = apple_valid && (new_head == apple_cord) && !wall_hit;
    assign len_grown    = (grow && (len_q != LEN_W'(MAX_LENGTH))) ? len_q + LEN_W'(1) : len_q;
    assign new_tail     = body_q[len_grown - LEN_W'(2)];

    snake_collide #(
        .MAX_LENGTH (MAX_LENGTH),
        .LEN_W      (LEN_W)
    ) u_collide (
        .new_head (new_head_ext),
        .body     (body_q),
        .length   (len_q),
        .grow     (grow),
        .wall_hit (wall_hit),
        .self_hit (self_hit)
    );

    // Slots beyond the live length mirror the new tail so they never expose a free cell.
    assign moved_body[0] = new_head;
    genvar gi;
    generate
        for (gi = 1; gi < MAX_LENGTH; gi++) begin : g_shift
            assign moved_body[gi] = (LEN_W'(gi) < len_grown) ? body_q[gi-1] : new_tail;
        end
        for (gi = 0; gi < MAX_LENGTH; gi++) begin : g_px
            assign px_hit[gi] = (LEN_W'(gi) < len_q) && (body_q[gi] == {x, y});
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DEAD: if (start) state_d = RUN;
            RUN:        if (move_tick && (wall_hit || self_hit)) state_d = DEAD;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        game_over = (state_q == DEAD);
    end

    always_comb begin
        body_d     = body_q;
        len_d      = len_q;
        cur_dir_d  = cur_dir_q;
        next_dir_d = next_dir_q;
        good_d     = 1'b0;
        bad_d      = 1'b0;
        if ((state_q != RUN) && start) begin
            body_d     = INIT_LAYOUT;
            len_d      = LEN_W'(2);
            cur_dir_d  = RIGHT;
            next_dir_d = RIGHT;
        end else if (state_q == RUN) begin
            next_dir_d = dir_chosen;
            if (move_tick) begin
                if (wall_hit || self_hit) begin
                    bad_d = 1'b1;
                end else begin
                    body_d    = moved_body;
                    len_d     = len_grown;
                    cur_dir_d = dir_chosen;
                    good_d    = grow;
                end
            end
        end
    end

    assign snake_px_d = |px_hit;
    assign head_px_d  = (body_q[0] == {x, y});

    always_ff @(posedge clk) begin
        if (reset) begin
            body_q     <= INIT_LAYOUT;
            len_q      <= LEN_W'(2);
            cur_dir_q  <= RIGHT;
            next_dir_q <= RIGHT;
            good_q     <= 1'b0;
            bad_q      <= 1'b0;
            snake_px_q <= 1'b0;
            head_px_q  <= 1'b0;
        end else begin
            body_q     <= body_d;
            len_q      <= len_d;
            cur_dir_q  <= cur_dir_d;
            next_dir_q <= next_dir_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
            snake_px_q <= snake_px_d;
            head_px_q  <= head_px_d;
        end
    end

    assign body      = body_q;
    assign length    = len_q;
    assign good_coll = good_q;
    assign bad_coll  = bad_q;
    assign snake_px  = snake_px_q;
    assign head_px   = head_px_q;

endmodule

// File: tb/tb_snake_body.sv
// Randomized and directed bench for snake_body against a queue-based snake model.
module tb_snake_body;
    localparam int MAXL = 50;
    localparam int LW   = $clog2(MAXL + 1);
    localparam int S_IDLE = 0, S_RUN = 1, S_DEAD = 2;

    logic clk = 1'b0;
    logic reset, start, move_tick, dir_valid, apple_valid;
    logic [1:0] dir;
    logic [7:0] apple_cord;
    logic [3:0] qx, qy;
    logic [MAXL-1:0][7:0] body;
    logic [LW-1:0] length;
    logic good_coll, bad_coll, game_over, snake_px, head_px;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: the snake as a head-first queue of cells.
    logic [7:0] m_snake[$];
    int m_state, m_cur, m_next;
    bit m_good, m_bad, m_spx, m_hpx;
    bit model_ready = 0;
    bit rand_query  = 1;

    always #5 clk = ~clk;

    snake_body #(.MAX_LENGTH(MAXL), .LEN_W(LW)) dut (
        .clk(clk), .reset(reset), .start(start), .move_tick(move_tick),
        .dir_valid(dir_valid), .dir(dir), .apple_cord(apple_cord),
        .apple_valid(apple_valid), .x(qx), .y(qy), .body(body),
        .length(length), .good_coll(good_coll), .bad_coll(bad_coll),
        .game_over(game_over), .snake_px(snake_px), .head_px(head_px)
    );

    task automatic chk(input string name, input logic [MAXL*8-1:0] act,
                       input logic [MAXL*8-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int opposite(input int d);
        case (d)
            0: return 1;
            1: return 0;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [7:0] step4(input logic [7:0] h, input int d);
        logic [3:0] hx, hy;
        hx = h[7:4];
        hy = h[3:0];
        case (d)
            0: hy = hy - 4'd1;
            1: hy = hy + 4'd1;
            2: hx = hx - 4'd1;
            default: hx = hx + 4'd1;
        endcase
        return {hx, hy};
    endfunction

    task automatic model_init();
        m_snake = '{8'h35, 8'h25};
        m_cur   = 3;
        m_next  = 3;
    endtask

    always @(posedge clk) begin
        int hx, hy, d, lim;
        bit wall, grow, hit;
        logic [7:0] nh, h, q;
        q = {qx, qy};
        if (reset) begin
            model_init();
            m_state = S_IDLE;
            m_good = 0; m_bad = 0; m_spx = 0; m_hpx = 0;
            model_ready = 1;
        end else if (model_ready) begin
            m_spx = 0;
            foreach (m_snake[i]) if (m_snake[i] == q) m_spx = 1;
            m_hpx = (m_snake[0] == q);
            m_good = 0;
            m_bad  = 0;
            if (m_state != S_RUN) begin
                if (start) begin
                    model_init();
                    m_state = S_RUN;
                end
            end else begin
                d = m_next;
                if (dir_valid && int'(dir) != opposite(m_cur)) d = int'(dir);
                m_next = d;
                if (move_tick) begin
                    h  = m_snake[0];
                    hx = int'(h[7:4]);
                    hy = int'(h[3:0]);
                    case (d)
                        0: hy = hy - 1;
                        1: hy = hy + 1;
                        2: hx = hx - 1;
                        default: hx = hx + 1;
                    endcase
                    wall = (hx < 0) || (hx > 15) || (hy < 0) || (hy > 15);
                    nh   = {4'(hx), 4'(hy)};
                    grow = apple_valid && (nh == apple_cord) && !wall;
                    lim  = grow ? m_snake.size() : m_snake.size() - 1;
                    hit  = 0;
                    for (int i = 0; i < lim; i++) if (m_snake[i] == nh) hit = 1;
                    if (wall || hit) begin
                        m_bad   = 1;
                        m_state = S_DEAD;
                    end else begin
                        m_snake.push_front(nh);
                        if (!grow || m_snake.size() > MAXL) void'(m_snake.pop_back());
                        m_good = grow;
                        m_cur  = d;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [MAXL-1:0][7:0] exp_body;
        int sz;
        if (model_ready) begin
            sz = m_snake.size();
            for (int i = 0; i < MAXL; i++)
                exp_body[i] = (i < sz) ? m_snake[i] : m_snake[sz-1];
            chk("body", body, exp_body);
            chk("length", length, sz);
            chk("good_coll", good_coll, m_good);
            chk("bad_coll", bad_coll, m_bad);
            chk("game_over", game_over, m_state == S_DEAD);
            chk("snake_px", snake_px, m_spx);
            chk("head_px", head_px, m_hpx);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rand_query) begin
                if ($urandom_range(0, 1) == 1 && m_snake.size() > 0)
                    {qx, qy} = m_snake[$urandom_range(0, m_snake.size() - 1)];
                else
                    {qx, qy} = 8'($urandom);
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic tick(input bit dv, input logic [1:0] d, input bit av,
                        input logic [7:0] ap);
        cyc();
        move_tick = 1; dir_valid = dv; dir = d; apple_valid = av; apple_cord = ap;
        cyc();
        move_tick = 0; dir_valid = 0; apple_valid = 0;
    endtask

    task automatic do_reset_start();
        reset = 1; cyc(); reset = 0;
        start = 1; cyc(); start = 0;
    endtask

    function automatic logic [1:0] serp_dir(input logic [7:0] h);
        if (h[0]) return (h[7:4] == 4'hF) ? 2'd1 : 2'd3;
        return (h[7:4] == 4'h0) ? 2'd1 : 2'd2;
    endfunction

    initial begin
        int since;
        logic [7:0] h, ap;
        logic [1:0] sd;
        reset = 1; start = 0; move_tick = 0; dir_valid = 0; dir = 0;
        apple_valid = 0; apple_cord = 0; qx = 0; qy = 0;
        cyc(); cyc();
        chk("rst_len", length, 2);
        chk("rst_head", body[0], 8'h35);
        chk("rst_head_px", head_px, 0);
        reset = 0;

        // First move to the right, then eat an apple.
        start = 1; cyc(); start = 0;
        chk("start_run", game_over, 0);
        tick(0, 0, 0, 0);
        chk("m1_b0", body[0], 8'h45);
        chk("m1_b1", body[1], 8'h35);
        chk("m1_b2", body[2], 8'h35);
        chk("m1_b49", body[49], 8'h35);
        chk("m1_len", length, 2);
        tick(0, 0, 1, 8'h55);
        chk("eat_b0", body[0], 8'h55);
        chk("eat_b1", body[1], 8'h45);
        chk("eat_b2", body[2], 8'h35);
        chk("eat_len", length, 3);
        chk("eat_good", good_coll, 1);
        cyc();
        chk("eat_good_drop", good_coll, 0);
        tick(1, 2'd2, 0, 0);
        chk("rev_drop", body[0], 8'h65);
        tick(1, 2'd0, 0, 0);
        chk("turn_up", body[0], 8'h64);

        // Wall hit at the right edge.
        do_reset_start();
        for (int i = 0; i < 12; i++) tick(0, 0, 0, 0);
        chk("edge_head", body[0], 8'hF5);
        tick(0, 0, 0, 0);
        chk("wall_bad", bad_coll, 1);
        chk("wall_over", game_over, 1);
        chk("wall_hold", body[0], 8'hF5);
        cyc();
        chk("wall_bad_drop", bad_coll, 0);
        tick(0, 0, 0, 0);
        chk("dead_frozen", body[0], 8'hF5);
        start = 1; cyc(); start = 0;
        chk("restart_head", body[0], 8'h35);
        chk("restart_len", length, 2);
        chk("restart_over", game_over, 0);

        // Head enters the vacating tail cell: legal.
        tick(0, 0, 0, 0);
        tick(0, 0, 1, 8'h55);
        tick(0, 0, 1, 8'h65);
        tick(0, 0, 0, 0);
        tick(1, 2'd1, 0, 0);
        tick(1, 2'd2, 0, 0);
        tick(1, 2'd0, 0, 0);
        chk("tail_ok_bad", bad_coll, 0);
        chk("tail_ok_head", body[0], 8'h65);
        chk("tail_ok_len", length, 4);

        // Length 5 loop back onto body[3]: self hit.
        do_reset_start();
        tick(0, 0, 0, 0);
        tick(0, 0, 1, 8'h55);
        tick(0, 0, 1, 8'h65);
        tick(0, 0, 1, 8'h75);
        chk("len5", length, 5);
        tick(1, 2'd1, 0, 0);
        tick(1, 2'd2, 0, 0);
        tick(1, 2'd0, 0, 0);
        chk("self_bad", bad_coll, 1);
        chk("self_over", game_over, 1);
        chk("self_hold", body[0], 8'h66);

        // Serpentine growth up to and past the maximum length.
        do_reset_start();
        for (int i = 0; i < 55; i++) begin
            h  = m_snake[0];
            sd = serp_dir(h);
            ap = step4(h, int'(sd));
            tick(1, sd, 1, ap);
        end
        chk("max_len", length, MAXL);
        chk("max_good", good_coll, 1);
        chk("max_over", game_over, 0);

        // Reset mid-run with a coincident move_tick, then pixel queries.
        do_reset_start();
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
        cyc();
        rand_query = 0;
        qx = 4'h0; qy = 4'h0;
        reset = 1; move_tick = 1;
        cyc();
        reset = 0; move_tick = 0;
        chk("mid_rst_head", body[0], 8'h35);
        chk("mid_rst_len", length, 2);
        chk("mid_rst_over", game_over, 0);
        qx = 4'h3; qy = 4'h5;
        cyc();
        chk("q_head_px", head_px, 1);
        chk("q_snake_px", snake_px, 1);
        qx = 4'h2; qy = 4'h5;
        cyc();
        chk("q_body_head_px", head_px, 0);
        chk("q_body_snake_px", snake_px, 1);
        tick(0, 0, 0, 0);
        chk("idle_frozen", body[0], 8'h35);
        rand_query = 1;

        // Randomized play.
        since = 1;
        for (int n = 0; n < 6000; n++) begin
            cyc();
            reset     = ($urandom_range(0, 799) == 0);
            start     = ($urandom_range(0, 5) == 0);
            dir_valid = ($urandom_range(0, 2) == 0);
            dir       = 2'($urandom);
            if (since >= 1 && $urandom_range(0, 1) == 1) begin
                move_tick = 1;
                since = 0;
            end else begin
                move_tick = 0;
                since++;
            end
            h = m_snake[0];
            case ($urandom_range(0, 3))
                0: apple_cord = 8'($urandom);
                1, 2: apple_cord = step4(h, m_next);
                default: apple_cord = step4(h, int'($urandom_range(0, 3)));
            endcase
            apple_valid = ($urandom_range(0, 7) != 0);
        end
        cyc();
        reset = 0; start = 0; move_tick = 0; dir_valid = 0; apple_valid = 0;
        cyc(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
